param_alu: RTL

PARAM_ALU -- requirements
Module: param_alu

---
 rtl/param_alu.sv | 135 +++++++++++++
 1 files changed

// File: rtl/param_alu.sv
// Parameterised ALU: 1-cycle ADD/AND/XOR, pipelined MUL, in-order result FIFO with credit flow control.
// Build option PARAM_ALU_SUB_EN enables op 101 (SUB); without it op 101 decodes as reserved.
module param_alu #(
    parameter int WIDTH      = 8,
    parameter int MUL_STAGES = 3,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [2:0]           res_op,
    output logic                 err
);
    localparam int RW = 2 * WIDTH;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(OUT_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
`ifdef PARAM_ALU_SUB_EN
    localparam logic [2:0] OP_SUB = 3'b101;
`endif

    logic [RW-1:0]         a_ext, b_ext, one_val, mul_prod;
    logic                  is_one, is_mul, is_rsvd;
    logic                  accept, pop, wr_en, mul_busy;
    logic [RW+2:0]         wr_data;

    logic [MUL_STAGES-1:0] mul_v_q;
    logic [RW-1:0]         mul_p_q [MUL_STAGES];
    logic                  one_v_q;
    logic [RW-1:0]         one_val_q;
    logic [2:0]            one_op_q;
    logic                  err_q;
    logic [RW+2:0]         mem_q [OUT_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d, used_q, used_d;

    assign a_ext    = RW'(A);
    assign b_ext    = RW'(B);
    assign mul_prod = a_ext * b_ext;

    always_comb begin
        is_one  = 1'b0;
        is_mul  = 1'b0;
        one_val = '0;
        case (op)
            OP_ADD: begin is_one = 1'b1; one_val = a_ext + b_ext; end
            OP_AND: begin is_one = 1'b1; one_val = a_ext & b_ext; end
            OP_XOR: begin is_one = 1'b1; one_val = a_ext ^ b_ext; end
`ifdef PARAM_ALU_SUB_EN
            OP_SUB: begin is_one = 1'b1; one_val = a_ext - b_ext; end
`endif
            OP_MUL: is_mul = 1'b1;
            default: ;
        endcase
    end

    assign is_rsvd = !is_one && !is_mul && (op != OP_NOP);

    // A MUL in the last stage lands this edge, so a 1-cycle op accepted now lands after it.
    generate
        if (MUL_STAGES > 1) begin : g_busy
            assign mul_busy = |mul_v_q[MUL_STAGES-2:0];
        end else begin : g_no_busy
            assign mul_busy = 1'b0;
        end
    endgenerate

    assign ready     = !reset && (used_q < DEPTH_C) && !(mul_busy && is_one);
    assign accept    = start && ready;
    assign res_valid = !reset && (cnt_q != '0);
    assign pop       = res_valid && res_ready;
    assign result    = res_valid ? mem_q[rd_ptr_q][RW-1:0] : '0;
    assign res_op    = res_valid ? mem_q[rd_ptr_q][RW+2:RW] : '0;
    assign err       = !reset && err_q;

    assign wr_en   = mul_v_q[MUL_STAGES-1] || one_v_q;
    assign wr_data = mul_v_q[MUL_STAGES-1] ? {OP_MUL, mul_p_q[MUL_STAGES-1]}
                                           : {one_op_q, one_val_q};

    // Credits cover FIFO entries plus results still in flight.
    assign used_d   = used_q + CW'(accept && (is_one || is_mul)) - CW'(pop);
    assign cnt_d    = cnt_q + CW'(wr_en) - CW'(pop);
    assign wr_ptr_d = !wr_en ? wr_ptr_q : (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    assign rd_ptr_d = !pop   ? rd_ptr_q : (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_v_q  <= '0;
            one_v_q  <= 1'b0;
            err_q    <= 1'b0;
            used_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mul_v_q[0] <= accept && is_mul;
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_v_q[i] <= mul_v_q[i-1];
            end
            one_v_q  <= accept && is_one;
            err_q    <= accept && is_rsvd;
            used_q   <= used_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mul_p_q[0] <= mul_prod;
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_p_q[i] <= mul_p_q[i-1];
        end
        one_val_q <= one_val;
        one_op_q  <= op;
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
